// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-side transmitter: frame FSM states and frame length.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_D0     = 4'd2,
    ST_D1     = 4'd3,
    ST_D2     = 4'd4,
    ST_D3     = 4'd5,
    ST_D4     = 4'd6,
    ST_D5     = 4'd7,
    ST_D6     = 4'd8,
    ST_D7     = 4'd9,
    ST_PARITY = 4'd10,
    ST_STOP   = 4'd11
  } state_t;

  localparam int FRAME_BITS = 11;

endpackage

// File: rtl/ps2_tx_chan.sv
// One PS/2 device transmit channel: byte FIFO plus frame FSM stepped by the shared rise tick.
module ps2_tx_chan
  import ps2_pkg::*;
#(
  parameter int FIFO_BITS = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       tick,
  input  logic       clk_ps2,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       ps2_clk_in,
  input  logic       ovf_clr,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       full,
  output logic       overflow,
  output logic       busy
);

  localparam int DEPTH = 2 ** FIFO_BITS;
  localparam logic [FIFO_BITS-1:0] PTR_ONE = 1;
  localparam logic [FIFO_BITS:0]   CNT_ONE = 1;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] wptr;
  logic [FIFO_BITS-1:0] rptr;
  logic [FIFO_BITS:0]   count;
  state_t               state;
  logic [7:0]           shift;
  logic                 parity;
  logic                 data;
  logic                 pop;
  logic                 wr_ok;

  // The head byte leaves the FIFO only once its stop bit has been on the wire.
  assign pop      = tick && (state == ST_STOP);
  assign wr_ok    = wr && (!count[FIFO_BITS] || pop);
  assign full     = count[FIFO_BITS];
  assign busy     = (state != ST_IDLE) || (count != '0);
  assign ps2_clk  = clk_ps2 | (state == ST_IDLE);
  assign ps2_data = data;

  always_ff @(posedge clk_sys) begin
    if (wr_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
      if (wr_ok && !pop)      count <= count + CNT_ONE;
      else if (pop && !wr_ok) count <= count - CNT_ONE;
      // A dropped byte outranks a clear arriving in the same cycle.
      if (wr && !wr_ok)  overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      shift  <= 8'h00;
      parity <= 1'b0;
      data   <= 1'b1;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if ((count != '0) && ps2_clk_in) begin
            state  <= ST_START;
            data   <= 1'b0;
            shift  <= mem[rptr];
            parity <= 1'b1;
          end
        end
        ST_STOP: begin
          state <= ST_IDLE;
          data  <= 1'b1;
        end
        default: begin
          // Host inhibit before the stop bit abandons the frame; the byte stays queued.
          if (!ps2_clk_in) begin
            state <= ST_IDLE;
            data  <= 1'b1;
          end else if (state == ST_PARITY) begin
            state <= ST_STOP;
            data  <= 1'b1;
          end else if (state == ST_D7) begin
            state <= ST_PARITY;
            data  <= parity;
          end else begin
            state  <= state_t'(state + 4'd1);
            data   <= shift[0];
            shift  <= {1'b0, shift[7:1]};
            parity <= parity ^ shift[0];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_dev_tx.sv
// Multi-channel PS/2 device transmitter: one free-running bus-clock divider shared by all channels.
module ps2_dev_tx
  import ps2_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 4,
  parameter int PS2DIV    = 100
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [7:0]          din,
  input  logic [CHANNELS-1:0] wr,
  input  logic [CHANNELS-1:0] ps2_clk_in,
  input  logic [CHANNELS-1:0] ovf_clr,
  output logic [CHANNELS-1:0] ps2_clk,
  output logic [CHANNELS-1:0] ps2_data,
  output logic [CHANNELS-1:0] full,
  output logic [CHANNELS-1:0] overflow,
  output logic [CHANNELS-1:0] busy
);

  localparam int             DW      = $clog2(PS2DIV + 2);
  localparam logic [DW-1:0]  DIV_MAX = DW'(PS2DIV);
  localparam logic [DW-1:0]  DIV_ONE = 1;

  logic [DW-1:0] div_cnt;
  logic          clk_ps2;
  logic          tick;

  // The tick marks the cycle in which clk_ps2 goes high, so channel data changes on the rising edge.
  assign tick = (div_cnt == DIV_MAX) && !clk_ps2;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      clk_ps2 <= 1'b0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
      clk_ps2 <= ~clk_ps2;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    ps2_tx_chan #(.FIFO_BITS(FIFO_BITS)) u_chan (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .tick       (tick),
      .clk_ps2    (clk_ps2),
      .din        (din),
      .wr         (wr[i]),
      .ps2_clk_in (ps2_clk_in[i]),
      .ovf_clr    (ovf_clr[i]),
      .ps2_clk    (ps2_clk[i]),
      .ps2_data   (ps2_data[i]),
      .full       (full[i]),
      .overflow   (overflow[i]),
      .busy       (busy[i])
    );
  end

endmodule
